mram_serial_ctrl: RTL

//  Parametrised successor MRAM access controller. Deserialises address and write data, then drives an

---
 rtl/mram_serial_ctrl_pkg.sv | 25 ++
 rtl/mram_serial_ctrl_if.sv | 27 ++
 rtl/stp_shift_reg.sv | 21 ++
 rtl/mram_serial_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mram_serial_ctrl_pkg.sv
// Shared types and helpers for the serial MRAM access controller.
package mram_serial_ctrl_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned POP_MAX_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    ACCESS,
    RECOV,
    READOUT
  } state_e;

  // Number of set bits; callers zero-extend narrower vectors to POP_MAX_W.
  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/mram_serial_ctrl_if.sv
// Host-side command handshake and serial link of the MRAM controller.
interface mram_serial_ctrl_if #(
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned LANES = DATA_W / 8;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [LANES-1:0] cmd_be;
  logic             ser_addr_in;
  logic             ser_data_in;
  logic             ser_data_out;
  logic             ser_data_valid;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_we, cmd_be, ser_addr_in, ser_data_in,
    input  cmd_ready, ser_data_out, ser_data_valid, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_be, ser_addr_in, ser_data_in,
    output cmd_ready, ser_data_out, ser_data_valid, busy, done
  );
endinterface

// File: rtl/stp_shift_reg.sv
// Serial-in parallel-out shift register, MSB arrives first.
module stp_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  // Truncating the concatenation drops the old MSB; also valid for W == 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= W'({q, din});
    end
  end

endmodule

// File: rtl/mram_serial_ctrl.sv
// Serial host link to async-SRAM-style MRAM bridge with lane enables and
// programmable access/recovery timing.
module mram_serial_ctrl
  import mram_serial_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned ACCESS_CYC = 2,
  parameter int unsigned RECOV_CYC  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  mram_serial_ctrl_if.slave       host,
  output logic [ADDR_W-1:0]       mram_addr,
  output logic [DATA_W-1:0]       mram_dq_out,
  output logic                    mram_dq_oe,
  input  logic [DATA_W-1:0]       mram_dq_in,
  output logic                    mram_ce_n,
  output logic                    mram_we_n,
  output logic                    mram_oe_n,
  output logic [DATA_W/8-1:0]     mram_be_n
);

  localparam int unsigned LANES     = DATA_W / BYTE_W;
  localparam int unsigned N_WR      = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned MAX_A     = (N_WR > ACCESS_CYC) ? N_WR : ACCESS_CYC;
  localparam int unsigned MAX_PHASE = (MAX_A > RECOV_CYC) ? MAX_A : RECOV_CYC;
  localparam int unsigned CNT_W     = $clog2(MAX_PHASE + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, phase_len, rd_len;
  logic               accept, last;
  logic               we_q;
  logic [LANES-1:0]   be_q;
  logic [DATA_W-1:0]  rd_buf, pack;
  logic               addr_en, data_en;

  logic               ready_q, busy_q, done_q, sdo_q, sdv_q;
  logic               ce_n_q, we_n_q, oe_n_q, dq_oe_q;
  logic [LANES-1:0]   be_n_q;
  logic               ready_d, busy_d, done_d, sdo_d, sdv_d;
  logic               ce_n_d, we_n_d, oe_n_d, dq_oe_d;
  logic [LANES-1:0]   be_n_d;

  assign rd_len = CNT_W'(BYTE_W * popcount(POP_MAX_W'(be_q)));

  // Next state, phase counter and next values of all registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    done_d    = 1'b0;
    accept    = 1'b0;
    phase_len = CNT_W'(1);
    case (state_q)
      SHIFT:   phase_len = we_q ? CNT_W'(N_WR) : CNT_W'(ADDR_W);
      ACCESS:  phase_len = CNT_W'(ACCESS_CYC);
      RECOV:   phase_len = CNT_W'(RECOV_CYC);
      READOUT: phase_len = rd_len;
      default: phase_len = CNT_W'(1);
    endcase
    last = (cnt_q == phase_len - CNT_W'(1));

    case (state_q)
      IDLE: begin
        if (host.cmd_valid) begin
          accept = 1'b1;
          if (host.cmd_be != '0) state_d = SHIFT;
          else                   done_d  = 1'b1;
        end
      end
      SHIFT:  if (last) state_d = ACCESS;
      ACCESS: if (last) state_d = RECOV;
      RECOV: begin
        if (last) begin
          if (we_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = READOUT;
          end
        end
      end
      READOUT: begin
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == state_q && state_q != IDLE) cnt_d = cnt_q + CNT_W'(1);

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    ce_n_d  = (state_d != ACCESS);
    we_n_d  = !(state_d == ACCESS && we_q);
    oe_n_d  = !(state_d == ACCESS && !we_q);
    dq_oe_d = (state_d == ACCESS) && we_q;
    be_n_d  = (state_d == ACCESS) ? ~be_q : '1;
    sdv_d   = (state_d == READOUT);
    sdo_d   = (state_d == READOUT) ? rd_buf[DATA_W-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sdo_q   <= 1'b0;
      sdv_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      be_n_q  <= '1;
    end else begin
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sdo_q   <= sdo_d;
      sdv_q   <= sdv_d;
      ce_n_q  <= ce_n_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
      dq_oe_q <= dq_oe_d;
      be_n_q  <= be_n_d;
    end
  end

  // Enabled lanes packed toward the MSB in ascending lane order, so the
  // readout is a plain MSB-first shift that skips disabled lanes.
  always_comb begin
    int unsigned k;
    pack = '0;
    k    = 0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (be_q[i]) begin
        pack[(LANES - 1 - k) * BYTE_W +: BYTE_W] = mram_dq_in[i * BYTE_W +: BYTE_W];
        k = k + 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q   <= 1'b0;
      be_q   <= '0;
      rd_buf <= '0;
    end else begin
      if (accept) begin
        we_q <= host.cmd_we;
        be_q <= host.cmd_be;
      end
      if (state_q == ACCESS && last) begin
        rd_buf <= pack;
      end else if (state_d == READOUT) begin
        rd_buf <= {rd_buf[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign addr_en = (state_q == SHIFT) && (cnt_q < CNT_W'(ADDR_W));
  assign data_en = (state_q == SHIFT) && we_q && (cnt_q < CNT_W'(DATA_W));

  stp_shift_reg #(.W(ADDR_W)) u_addr_sr (
    .clk (clk),
    .rst (rst),
    .en  (addr_en),
    .din (host.ser_addr_in),
    .q   (mram_addr)
  );

  stp_shift_reg #(.W(DATA_W)) u_data_sr (
    .clk (clk),
    .rst (rst),
    .en  (data_en),
    .din (host.ser_data_in),
    .q   (mram_dq_out)
  );

  assign host.cmd_ready      = ready_q;
  assign host.busy           = busy_q;
  assign host.done           = done_q;
  assign host.ser_data_out   = sdo_q;
  assign host.ser_data_valid = sdv_q;
  assign mram_ce_n           = ce_n_q;
  assign mram_we_n           = we_n_q;
  assign mram_oe_n           = oe_n_q;
  assign mram_dq_oe          = dq_oe_q;
  assign mram_be_n           = be_n_q;

endmodule
